// File: rtl/pong_menu_select_if.sv
// Video/ROM bus of the Pong menu front-end: sync-generator coordinates in,
// item-local coordinates out to the item ROMs, ROM pixels back, and the
// composited 3-3-2 pixel stream out.
interface pong_menu_select_if #(
  parameter int N_ITEMS = 2
);
  logic [9:0]           xpos;
  logic [9:0]           ypos;
  logic                 video_on;
  logic [9:0]           item_x;
  logic [9:0]           item_y;
  logic [8*N_ITEMS-1:0] item_rgb;
  logic [2:0]           red;
  logic [2:0]           green;
  logic [1:0]           blue;

  modport slave (
    input  xpos, ypos, video_on, item_rgb,
    output item_x, item_y, red, green, blue
  );

  modport master (
    output xpos, ypos, video_on, item_rgb,
    input  item_x, item_y, red, green, blue
  );
endinterface

// File: rtl/pong_menu_select.sv
// Pong title-screen menu: maps screen coordinates onto item-local ROM
// coordinates, composites the item ROM pixels with a selection highlight
// (3-clock pixel latency) and runs the MENU -> CONFIRM -> DONE cursor FSM.
// Optional feature macro: PONG_MENU_WRAP_EN (cursor wraps instead of saturating).
module pong_menu_select #(
  parameter int         N_ITEMS        = 2,
  parameter int         MENU_X         = 256,
  parameter int         MENU_Y         = 200,
  parameter int         ITEM_W         = 80,
  parameter int         ITEM_PITCH     = 24,
  parameter logic [7:0] HILITE_RGB     = 8'b000_000_10,
  parameter int         CONFIRM_FRAMES = 32
) (
  input  logic               clk,
  input  logic               reset,
  pong_menu_select_if.slave  vid,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_sel,
  input  logic               resume,
  output logic [1:0]         menu_sel,
  output logic               menu_active,
  output logic               start_game
);

  // Counter must hold CONFIRM_FRAMES and always expose bit 2 for the blink.
  localparam int CW = ($clog2(CONFIRM_FRAMES + 1) > 3) ? $clog2(CONFIRM_FRAMES + 1) : 3;
  localparam logic [10:0]   X_LO     = 11'(MENU_X);
  localparam logic [10:0]   X_HI     = 11'(MENU_X + ITEM_W);
  localparam logic [1:0]    LAST_SEL = 2'(N_ITEMS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CONFIRM_FRAMES - 1);

  typedef enum logic [1:0] {
    S_MENU    = 2'd0,
    S_CONFIRM = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t        state_r, next_state_s;
  logic [CW-1:0] frame_cnt_r, cnt_next_s;
  logic [1:0]    sel_next_s;
  logic          start_next_s;

  logic [2:0]    btn_cur_r, btn_prev_r, btn_arm_r;
  logic [2:0]    btn_edge_s;
  logic          prev_origin_r, at_origin_s, frame_tick_s;

  logic          band_hit_s;
  logic [1:0]    band_idx_s;
  logic [9:0]    local_x_s, local_y_s;
  logic          hit_d1_r, hit_d2_r, von_d1_r, von_d2_r;
  logic [1:0]    idx_d1_r, idx_d2_r;
  logic [7:0]    rom_pix_s, pix_s;
  logic          hilite_s;

  function automatic logic [1:0] sel_up(input logic [1:0] s);
`ifdef PONG_MENU_WRAP_EN
    if (s == 2'd0) sel_up = LAST_SEL;
    else           sel_up = s - 2'd1;
`else
    if (s == 2'd0) sel_up = s;
    else           sel_up = s - 2'd1;
`endif
  endfunction

  function automatic logic [1:0] sel_down(input logic [1:0] s);
`ifdef PONG_MENU_WRAP_EN
    if (s == LAST_SEL) sel_down = 2'd0;
    else               sel_down = s + 2'd1;
`else
    if (s == LAST_SEL) sel_down = s;
    else               sel_down = s + 2'd1;
`endif
  endfunction

  // Band decode: which item band (if any) covers the current pixel, and its local coordinates.
  always_comb begin
    band_hit_s = 1'b0;
    band_idx_s = 2'd0;
    local_x_s  = 10'h3FF;
    local_y_s  = 10'h3FF;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (({1'b0, vid.xpos} >= X_LO) && ({1'b0, vid.xpos} < X_HI) &&
          ({1'b0, vid.ypos} >= 11'(MENU_Y + i * ITEM_PITCH)) &&
          ({1'b0, vid.ypos} <  11'(MENU_Y + (i + 1) * ITEM_PITCH))) begin
        band_hit_s = 1'b1;
        band_idx_s = 2'(i);
        local_x_s  = vid.xpos - X_LO[9:0];
        local_y_s  = vid.ypos - 10'(MENU_Y + i * ITEM_PITCH);
      end else begin
        band_hit_s = band_hit_s;
      end
    end
  end

  // Pixel pipeline: register ROM address, then delay band info to meet the ROM data, then the output pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid.item_x <= 10'h3FF;
      vid.item_y <= 10'h3FF;
      hit_d1_r   <= 1'b0;
      hit_d2_r   <= 1'b0;
      von_d1_r   <= 1'b0;
      von_d2_r   <= 1'b0;
      idx_d1_r   <= 2'd0;
      idx_d2_r   <= 2'd0;
      vid.red    <= 3'd0;
      vid.green  <= 3'd0;
      vid.blue   <= 2'd0;
    end else begin
      vid.item_x <= local_x_s;
      vid.item_y <= local_y_s;
      hit_d1_r   <= band_hit_s;
      hit_d2_r   <= hit_d1_r;
      von_d1_r   <= vid.video_on;
      von_d2_r   <= von_d1_r;
      idx_d1_r   <= band_idx_s;
      idx_d2_r   <= idx_d1_r;
      vid.red    <= pix_s[7:5];
      vid.green  <= pix_s[4:2];
      vid.blue   <= pix_s[1:0];
    end
  end

  // Highlight enable: steady in MENU, blinks on frame-counter bit 2 in CONFIRM, off in DONE.
  always_comb begin
    case (state_r)
      S_MENU:    hilite_s = 1'b1;
      S_CONFIRM: hilite_s = ~frame_cnt_r[2];
      default:   hilite_s = 1'b0;
    endcase
  end

  // Compositor: ROM pixel wins, otherwise highlight fill on the selected band, otherwise black.
  always_comb begin
    rom_pix_s = 8'h00;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (idx_d2_r == 2'(i)) rom_pix_s = vid.item_rgb[8*i +: 8];
      else                   rom_pix_s = rom_pix_s;
    end
    if (!von_d2_r || !hit_d2_r || (state_r == S_DONE)) pix_s = 8'h00;
    else if (rom_pix_s != 8'h00)                        pix_s = rom_pix_s;
    else if ((idx_d2_r == menu_sel) && hilite_s)        pix_s = HILITE_RGB;
    else                                                pix_s = 8'h00;
  end

  // Button and frame-origin history; a button only arms once it has been seen low after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_cur_r     <= 3'b000;
      btn_prev_r    <= 3'b000;
      btn_arm_r     <= 3'b000;
      prev_origin_r <= 1'b0;
    end else begin
      btn_cur_r     <= {btn_sel, btn_down, btn_up};
      btn_prev_r    <= btn_cur_r;
      btn_arm_r     <= btn_arm_r | ~{btn_sel, btn_down, btn_up};
      prev_origin_r <= at_origin_s;
    end
  end

  assign btn_edge_s   = btn_cur_r & ~btn_prev_r & btn_arm_r;
  assign at_origin_s  = (vid.xpos == 10'd0) && (vid.ypos == 10'd0);
  assign frame_tick_s = at_origin_s & ~prev_origin_r;

  // Next-state logic: cursor moves in MENU, frame counting in CONFIRM, wait for resume in DONE.
  always_comb begin
    next_state_s = state_r;
    sel_next_s   = menu_sel;
    cnt_next_s   = frame_cnt_r;
    start_next_s = 1'b0;
    case (state_r)
      S_MENU: begin
        if (btn_edge_s[2])                         next_state_s = S_CONFIRM;
        else if (btn_edge_s[0] && !btn_edge_s[1])  sel_next_s   = sel_up(menu_sel);
        else if (btn_edge_s[1] && !btn_edge_s[0])  sel_next_s   = sel_down(menu_sel);
        else                                       sel_next_s   = menu_sel;
      end
      S_CONFIRM: begin
        if (frame_tick_s) begin
          cnt_next_s = frame_cnt_r + CW'(1);
          if (frame_cnt_r == CNT_LAST) begin
            next_state_s = S_DONE;
            start_next_s = 1'b1;
          end else begin
            next_state_s = S_CONFIRM;
          end
        end else begin
          cnt_next_s = frame_cnt_r;
        end
      end
      S_DONE: begin
        if (resume) begin
          next_state_s = S_MENU;
          cnt_next_s   = '0;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: begin
        next_state_s = S_MENU;
        cnt_next_s   = '0;
      end
    endcase
  end

  // FSM state, cursor, frame counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_MENU;
      frame_cnt_r <= '0;
      menu_sel    <= 2'd0;
      menu_active <= 1'b1;
      start_game  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      frame_cnt_r <= cnt_next_s;
      menu_sel    <= sel_next_s;
      menu_active <= (next_state_s != S_DONE);
      start_game  <= start_next_s;
    end
  end

endmodule

// File: tb/tb_pong_menu_select.sv
// Self-checking bench for pong_menu_select: a per-cycle reference model of
// the menu behaviour plus directed, hand-computed pixel and cursor checks.
module tb_pong_menu_select;
  localparam int N = 2;

  typedef struct {
    bit valid;
    bit von;
    int x;
    int y;
  } px_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_sel, resume;
  logic [1:0] menu_sel;
  logic       menu_active, start_game;
  bit   [7:0] rom_q [N];

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit check_en = 0;

  // reference model state
  int       m_state, m_sel, m_ticks, nsamp;
  px_t      h1, h2;
  bit [2:0] b1, b2;
  bit       m_prev_origin;
  logic [7:0] exp_rgb;
  int       exp_ix, exp_iy;
  bit       exp_start, exp_active;

  int xs [7] = '{255, 256, 258, 300, 335, 336, 340};
  int ys [9] = '{199, 200, 206, 223, 224, 230, 247, 248, 250};

  pong_menu_select_if #(.N_ITEMS(N)) vid ();

  pong_menu_select #(.N_ITEMS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .vid        (vid),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_sel    (btn_sel),
    .resume     (resume),
    .menu_sel   (menu_sel),
    .menu_active(menu_active),
    .start_game (start_game)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(int i, int lx, int ly);
    if (lx == 2 && ly == 6)   return 8'hFF;
    if (lx == 79 && ly == 23) return 8'h24 + 8'(i);
    if (lx == 0 && ly == 0)   return 8'h80 | 8'(i);
    return 8'h00;
  endfunction

  // registered item ROMs driven by the DUT's item coordinates
  always @(posedge clk)
    for (int i = 0; i < N; i++) rom_q[i] <= rom_fn(i, int'(vid.item_x), int'(vid.item_y));

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign vid.item_rgb[8*g +: 8] = rom_q[g];
  end

  function automatic bit in_band(int x, int y, output int bi, output int lx, output int ly);
    bi = 0; lx = 1023; ly = 1023;
    if (x < 256 || x >= 336) return 1'b0;
    for (int i = 0; i < N; i++)
      if (y >= 200 + 24 * i && y < 224 + 24 * i) begin
        bi = i; lx = x - 256; ly = y - 200 - 24 * i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_pixel(px_t p);
    int bi, lx, ly;
    bit hl;
    logic [7:0] r;
    if (!p.valid || !p.von || m_state == 2) return 8'h00;
    if (!in_band(p.x, p.y, bi, lx, ly)) return 8'h00;
    r = rom_fn(bi, lx, ly);
    if (r != 8'h00) return r;
    hl = (m_state == 0) || (((m_ticks / 4) % 2) == 0);
    if (bi == m_sel && hl) return 8'b000_000_10;
    return 8'h00;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  // reference model step and per-cycle comparison
  always @(posedge clk) begin
    px_t cur;
    bit [2:0] bcur, rise;
    bit tick, org;
    int bi, lx, ly;
    cur.valid = 1'b1;
    cur.von = vid.video_on;
    cur.x = int'(vid.xpos);
    cur.y = int'(vid.ypos);
    bcur = {btn_sel, btn_down, btn_up};
    if (reset) begin
      m_state = 0; m_sel = 0; m_ticks = 0; nsamp = 0;
      h1 = '{default: 0}; h2 = '{default: 0};
      b1 = 3'b000; b2 = 3'b000; m_prev_origin = 1'b0;
      exp_rgb = 8'h00; exp_ix = 1023; exp_iy = 1023;
      exp_start = 1'b0; exp_active = 1'b1;
      check_en = 1'b1;
    end else begin
      exp_rgb = model_pixel(h2);
      h2 = h1;
      h1 = cur;
      void'(in_band(cur.x, cur.y, bi, lx, ly));
      exp_ix = lx;
      exp_iy = ly;
      org = (cur.x == 0 && cur.y == 0);
      tick = org && !m_prev_origin;
      m_prev_origin = org;
      rise = (nsamp >= 2) ? (b1 & ~b2) : 3'b000;
      exp_start = 1'b0;
      case (m_state)
        0: begin
          if (rise[2]) m_state = 1;
          else if (rise[0] && !rise[1]) begin
`ifdef PONG_MENU_WRAP_EN
            m_sel = (m_sel + N - 1) % N;
`else
            m_sel = (m_sel > 0) ? m_sel - 1 : 0;
`endif
          end else if (rise[1] && !rise[0]) begin
`ifdef PONG_MENU_WRAP_EN
            m_sel = (m_sel + 1) % N;
`else
            m_sel = (m_sel < N - 1) ? m_sel + 1 : m_sel;
`endif
          end
        end
        1: if (tick) begin
          m_ticks++;
          if (m_ticks == 32) begin m_state = 2; exp_start = 1'b1; end
        end
        default: if (resume) begin m_state = 0; m_ticks = 0; end
      endcase
      exp_active = (m_state != 2);
      b2 = b1;
      b1 = bcur;
      if (nsamp < 2) nsamp++;
    end
    #1;
    if (check_en) begin
      chk("cyc_rgb", {vid.red, vid.green, vid.blue}, exp_rgb);
      chk("cyc_item_x", vid.item_x, exp_ix);
      chk("cyc_item_y", vid.item_y, exp_iy);
      chk("cyc_menu_sel", menu_sel, m_sel);
      chk("cyc_menu_active", menu_active, exp_active);
      chk("cyc_start_game", start_game, exp_start);
      if (start_game === 1'b1) start_cnt++;
    end
  end

  task automatic step(int x, int y, bit v);
    @(negedge clk);
    vid.xpos = 10'(x);
    vid.ypos = 10'(y);
    vid.video_on = v;
  endtask

  task automatic frame();
    step(0, 0, 1'b1);
    foreach (ys[r]) foreach (xs[c]) step(xs[c], ys[r], ys[r] != 250);
    step(700, 500, 1'b0);
  endtask

  task automatic frames(int n);
    repeat (n) frame();
  endtask

  task automatic pin(string nm, int x, int y, bit v, int eix, int eiy, logic [7:0] ergb);
    step(x, y, v);
    @(posedge clk); #1;
    chk({nm, "_ix"}, vid.item_x, eix);
    chk({nm, "_iy"}, vid.item_y, eiy);
    step(700, 500, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk({nm, "_rgb"}, {vid.red, vid.green, vid.blue}, ergb);
  endtask

  task automatic btn_pulse(bit u, bit d, bit s, int hold);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_sel = s;
    repeat (hold) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(int n);
    @(negedge clk) reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int s0;
    reset = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; resume = 1'b0;
    vid.xpos = 10'd700; vid.ypos = 10'd500; vid.video_on = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_menu_sel", menu_sel, 2'd0);
    chk("rst_menu_active", menu_active, 1'b1);
    chk("rst_start_game", start_game, 1'b0);
    chk("rst_item_x", vid.item_x, 10'h3FF);
    chk("rst_rgb", {vid.red, vid.green, vid.blue}, 8'h00);

    frame();
    pin("rom_ff", 258, 206, 1'b1, 2, 6, 8'hFF);
    pin("von_off", 258, 206, 1'b0, 2, 6, 8'h00);
    pin("outside", 100, 100, 1'b1, 1023, 1023, 8'h00);
    pin("x_edge", 336, 210, 1'b1, 1023, 1023, 8'h00);
    pin("hl_b0", 300, 210, 1'b1, 44, 10, 8'h02);
    pin("b1_unsel", 300, 230, 1'b1, 44, 6, 8'h00);
    pin("rom_b1_org", 256, 224, 1'b1, 0, 0, 8'h81);
    pin("rom_b1_end", 335, 247, 1'b1, 79, 23, 8'h25);

    btn_pulse(1'b0, 1'b1, 1'b0, 2);
    chk("down1_sel", menu_sel, 2'd1);
    pin("hl_b1", 300, 230, 1'b1, 44, 6, 8'h02);
    pin("b0_unsel", 300, 210, 1'b1, 44, 10, 8'h00);
    btn_pulse(1'b0, 1'b1, 1'b0, 2);
`ifdef PONG_MENU_WRAP_EN
    chk("down2_sel", menu_sel, 2'd0);
    btn_pulse(1'b0, 1'b1, 1'b0, 2);
`else
    chk("down2_sel", menu_sel, 2'd1);
`endif
    btn_pulse(1'b1, 1'b1, 1'b0, 2);
    chk("updown_sel", menu_sel, 2'd1);
    btn_pulse(1'b1, 1'b0, 1'b0, 2);
    chk("up_sel", menu_sel, 2'd0);
    btn_pulse(1'b0, 1'b1, 1'b0, 1000);
    chk("hold_sel", menu_sel, 2'd1);

    btn_pulse(1'b0, 1'b0, 1'b1, 2);
    pin("cf_t0", 300, 230, 1'b1, 44, 6, 8'h02);
    frames(4);
    pin("cf_t4", 300, 230, 1'b1, 44, 6, 8'h00);
    frames(4);
    pin("cf_t8", 300, 230, 1'b1, 44, 6, 8'h02);
    btn_pulse(1'b1, 1'b0, 1'b0, 2);
    chk("cf_btn_ignored", menu_sel, 2'd1);
    frames(23);
    chk("cf_t31_nostart", start_cnt, 0);
    chk("cf_t31_active", menu_active, 1'b1);
    frame();
    chk("cf_start_once", start_cnt, 1);
    chk("done_active", menu_active, 1'b0);
    chk("done_start_low", start_game, 1'b0);
    pin("done_rgb", 258, 206, 1'b1, 2, 6, 8'h00);

    btn_pulse(1'b0, 1'b1, 1'b0, 2);
    btn_pulse(1'b1, 1'b0, 1'b0, 2);
    btn_pulse(1'b0, 1'b0, 1'b1, 2);
    chk("done_btn_sel", menu_sel, 2'd1);
    chk("done_btn_active", menu_active, 1'b0);
    @(negedge clk) resume = 1'b1;
    @(negedge clk) resume = 1'b0;
    repeat (2) @(negedge clk);
    chk("resume_active", menu_active, 1'b1);
    chk("resume_sel", menu_sel, 2'd1);
    pin("resume_hl", 300, 230, 1'b1, 44, 6, 8'h02);

    btn_pulse(1'b0, 1'b0, 1'b1, 2);
    frames(10);
    s0 = start_cnt;
    do_reset(2);
    chk("rst_cf_sel", menu_sel, 2'd0);
    chk("rst_cf_active", menu_active, 1'b1);
    frames(64);
    chk("rst_cf_nostart", start_cnt, s0);
    chk("rst_cf_menu", menu_active, 1'b1);

    @(negedge clk) btn_down = 1'b1;
    do_reset(2);
    repeat (20) @(negedge clk);
    chk("held_rst_sel", menu_sel, 2'd0);
    btn_down = 1'b0;
    repeat (3) @(negedge clk);
    btn_pulse(1'b0, 1'b1, 1'b0, 2);
    chk("after_held_sel", menu_sel, 2'd1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
